// File: rtl/xor_nn_pkg.sv
// Shared types and constants for the XOR neural-network core and its sequencer.
// Q8.8 activations are 16-bit signed: 8 integer bits, 8 fraction bits.
package xor_nn_pkg;

    localparam int XOR_NN_LATENCY = 6;

    typedef logic signed [15:0] q88_t;

    localparam q88_t Q88_ONE  = 16'sh0100;
    localparam q88_t Q88_ZERO = 16'sh0000;

endpackage

// File: rtl/xor_nn_seq_check.sv
// Golden XOR reference that travels alongside the core pipeline and flags wrong decisions.
// Compiled and instantiated only when XOR_NN_SEQ_CHECK_EN is defined.
`ifdef XOR_NN_SEQ_CHECK_EN
module xor_nn_seq_check
    import xor_nn_pkg::*;
#(
    parameter int LATENCY = XOR_NN_LATENCY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_advance,
    input  logic       i_fire,
    input  logic       i_gold_bit,
    input  logic       i_vld_last,
    input  logic       i_consume,
    input  logic       i_out_class,
    output logic       o_err_sticky,
    output logic [7:0] o_err_count
);

    logic [LATENCY-1:0] r_gold;
    logic               r_expected;
    logic               r_err_sticky;
    logic [7:0]         r_err_count;

    // Shifts on exactly the same edges as the valid tracker, so the golden bit
    // at the last stage always belongs to the sample the core is presenting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gold       <= '0;
            r_expected   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (i_advance) begin
                r_gold <= {r_gold[LATENCY-2:0], i_fire & i_gold_bit};
                if (i_vld_last)
                    r_expected <= r_gold[LATENCY-1];
            end
            if (i_consume && (i_out_class != r_expected)) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != 8'hFF)
                    r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_err_sticky = r_err_sticky;
    assign o_err_count  = r_err_count;

endmodule
`endif

// File: rtl/xor_nn_seq.sv
// Streaming valid/ready wrapper around the 6-stage XOR NN core; stalls the core on back-pressure.
// Optional golden-model checker and error ports are enabled by XOR_NN_SEQ_CHECK_EN.
module xor_nn_seq
    import xor_nn_pkg::*;
#(
    parameter int          LATENCY = XOR_NN_LATENCY,
    parameter logic [15:0] ONE_Q88 = Q88_ONE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_a,
    input  logic        in_b,
    output logic        nn_en,
    output logic [15:0] nn_x1,
    output logic [15:0] nn_x2,
    input  logic        nn_cl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_class,
    output logic        busy,
    output logic [15:0] out_count
`ifdef XOR_NN_SEQ_CHECK_EN
    ,
    output logic        err_sticky,
    output logic [7:0]  err_count
`endif
);

    logic               w_advance;
    logic               w_fire;
    logic               w_consume;
    logic [LATENCY-1:0] r_vld;
    logic               r_out_valid;
    logic               r_out_class;
    logic [15:0]        r_out_count;

    // The whole pipeline moves as one: a held result freezes the core and the input together.
    assign w_advance = ~rst & (~r_out_valid | out_ready);
    assign w_fire    = in_valid & w_advance;
    assign w_consume = r_out_valid & out_ready;

    assign nn_en    = w_advance;
    assign in_ready = w_advance;
    assign nn_x1    = (w_fire & in_a) ? ONE_Q88 : Q88_ZERO;
    assign nn_x2    = (w_fire & in_b) ? ONE_Q88 : Q88_ZERO;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_out_class <= 1'b0;
        end else if (w_advance) begin
            r_vld       <= {r_vld[LATENCY-2:0], w_fire};
            r_out_valid <= r_vld[LATENCY-1];
            if (r_vld[LATENCY-1])
                r_out_class <= nn_cl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_out_count <= '0;
        else if (w_consume)
            r_out_count <= r_out_count + 16'd1;
    end

    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_count = r_out_count;
    assign busy      = (|r_vld) | r_out_valid;

`ifdef XOR_NN_SEQ_CHECK_EN
    xor_nn_seq_check #(
        .LATENCY (LATENCY)
    ) u_check (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (w_advance),
        .i_fire       (w_fire),
        .i_gold_bit   (in_a ^ in_b),
        .i_vld_last   (r_vld[LATENCY-1]),
        .i_consume    (w_consume),
        .i_out_class  (r_out_class),
        .o_err_sticky (err_sticky),
        .o_err_count  (err_count)
    );
`endif

endmodule
